// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall unit.
package hazard_pkg;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // A producer only counts when it really writes a nonzero register the consumer reads.
  function automatic logic reg_match(input logic [4:0] src, input logic uses,
                                     input logic wr, input logic [4:0] rd);
    return (src != 5'd0) && uses && wr && (src == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_wr, input logic [4:0] mem_rd,
                                         input logic wb_wr, input logic [4:0] wb_rd);
    if (reg_match(src, 1'b1, mem_wr, mem_rd)) return FWD_MEM;
    if (reg_match(src, 1'b1, wb_wr, wb_rd)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/mul_stall_counter.sv
// Tracks how long a multi-cycle mul has occupied EX and raises the front-end stall.
module mul_stall_counter
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic is_mul,
  output logic stall,
  output logic busy
);

  localparam int CW = $clog2(MUL_LATENCY) + 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_LATENCY - 1);
  localparam bit MUL_EN = (MUL_LATENCY > 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic release_cycle;

  // The last count is the cycle the mul result leaves EX, so the front end may move.
  assign release_cycle = (state == MUL_WAIT) && (cnt == LAST);
  assign stall = MUL_EN && is_mul && !release_cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MUL_EN && is_mul) begin
            state <= MUL_WAIT;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        MUL_WAIT: begin
          if (cnt == LAST) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline sequencer: mul occupancy, redirects, RAW/load-use stalls and EX forwarding.
// Optional operand forwarding is enabled with `define FORWARDING_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_Rs,
  input  logic [4:0] EX_Rt,
  input  logic [4:0] EX_Rd,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic       EX_IsMul,
  input  logic       EX_Redirect,
  input  logic [4:0] MEM_Rd,
  input  logic [4:0] WB_Rd,
  input  logic       MEM_RegWrite,
  input  logic       WB_RegWrite,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Bubble,
  output logic [1:0] FwdA,
  output logic [1:0] FwdB,
  output logic       MulBusy
);

  logic mul_stall;
  logic mul_busy;
  logic raw_stall;
  logic ex_match;

  mul_stall_counter #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
    .clk   (Clk),
    .rst   (Reset),
    .is_mul(EX_IsMul),
    .stall (mul_stall),
    .busy  (mul_busy)
  );

  assign ex_match = reg_match(ID_Rs, ID_UsesRs, EX_RegWrite, EX_Rd)
                  | reg_match(ID_Rt, ID_UsesRt, EX_RegWrite, EX_Rd);

`ifdef FORWARDING_EN
  // Only a load cannot be forwarded in time; everything else is bypassed into EX.
  assign raw_stall = EX_MemRead && ex_match;
  assign FwdA = Reset ? FWD_REG : fwd_sel(EX_Rs, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);
  assign FwdB = Reset ? FWD_REG : fwd_sel(EX_Rt, MEM_RegWrite, MEM_Rd, WB_RegWrite, WB_Rd);
`else
  // WB is absent: the register file writes before it reads in the same cycle.
  assign raw_stall = ex_match
                   | reg_match(ID_Rs, ID_UsesRs, MEM_RegWrite, MEM_Rd)
                   | reg_match(ID_Rt, ID_UsesRt, MEM_RegWrite, MEM_Rd);
  assign FwdA = FWD_REG;
  assign FwdB = FWD_REG;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{EX_Rs, EX_Rt, EX_MemRead, WB_Rd, WB_RegWrite};
`endif

  assign MulBusy = mul_busy;

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    if (Reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Write = 1'b0;
    end else if (mul_stall) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Bubble = 1'b1;
    end else if (EX_Redirect) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (raw_stall) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed checks of stall, redirect, mul occupancy and forwarding controls.
module tb_hazard_stall_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
  logic       ID_UsesRs, ID_UsesRt, EX_RegWrite, EX_MemRead, EX_IsMul, EX_Redirect;
  logic       MEM_RegWrite, WB_RegWrite;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble;
  logic [1:0] FwdA, FwdB;
  logic       MulBusy;

  int checks = 0;
  int failures = 0;

  // Control bundle order: PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble
  localparam logic [5:0] CTL_RST   = 6'b000000;
  localparam logic [5:0] CTL_RUN   = 6'b110100;
  localparam logic [5:0] CTL_MUL   = 6'b000001;
  localparam logic [5:0] CTL_REDIR = 6'b111110;
  localparam logic [5:0] CTL_RAW   = 6'b000110;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [5:0] ctl;
  assign ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Bubble};

  hazard_stall_unit #(.MUL_LATENCY(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_IsMul(EX_IsMul), .EX_Redirect(EX_Redirect),
    .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_RegWrite(MEM_RegWrite), .WB_RegWrite(WB_RegWrite),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Flush(IDEX_Flush), .EXMEM_Bubble(EXMEM_Bubble),
    .FwdA(FwdA), .FwdB(FwdB), .MulBusy(MulBusy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end else begin
      $display("ok   %s value=%b", tag, got);
    end
  endtask

  task automatic idle();
    ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    EX_Rs = 0; EX_Rt = 0; EX_Rd = 0; EX_RegWrite = 0; EX_MemRead = 0;
    EX_IsMul = 0; EX_Redirect = 0;
    MEM_Rd = 0; WB_Rd = 0; MEM_RegWrite = 0; WB_RegWrite = 0;
  endtask

  // Advance one cycle and move away from the active edge before driving.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    EX_IsMul = 1'b1;
    #2;
    check("reset_ctl", {2'b0, ctl}, {2'b0, CTL_RST});
    check("reset_fwd", {4'b0, FwdA, FwdB}, 8'h00);
    check("reset_busy", {7'b0, MulBusy}, 8'h00);
    step();
    check("reset_hold_ctl", {2'b0, ctl}, {2'b0, CTL_RST});
    Reset = 1'b0;
    idle();
    #1;
    check("idle_ctl", {2'b0, ctl}, {2'b0, CTL_RUN});

    // $zero and an unused source never produce a hazard
    ID_Rs = 0; ID_UsesRs = 1; EX_Rd = 0; EX_RegWrite = 1; EX_MemRead = 1;
    #1 check("zero_reg_ctl", {2'b0, ctl}, {2'b0, CTL_RUN});
    ID_Rs = 8; ID_UsesRs = 0; EX_Rd = 8;
    #1 check("unused_src_ctl", {2'b0, ctl}, {2'b0, CTL_RUN});

    // Load-use: lw $t0 in EX, add reading $t0 in ID
    step(); idle();
    ID_Rs = 8; ID_UsesRs = 1; EX_Rd = 8; EX_RegWrite = 1; EX_MemRead = 1;
    #1 check("lw_use_c0", {2'b0, ctl}, {2'b0, CTL_RAW});
    step(); idle();
    ID_Rs = 8; ID_UsesRs = 1; MEM_Rd = 8; MEM_RegWrite = 1;
    #1 check("lw_use_c1", {2'b0, ctl}, {2'b0, (FWD ? CTL_RUN : CTL_RAW)});
    step(); idle();
    EX_Rs = 8; EX_Rd = 9; EX_RegWrite = 1; WB_Rd = 8; WB_RegWrite = 1;
    #1 check("lw_use_fwd", {6'b0, FwdA}, {6'b0, (FWD ? 2'b01 : 2'b00)});
    check("lw_use_c2", {2'b0, ctl}, {2'b0, CTL_RUN});
    step(); idle();
    ID_Rt = 8; ID_UsesRt = 1; EX_Rd = 8; EX_RegWrite = 1; EX_MemRead = 1;
    #1 check("lw_use_rt", {2'b0, ctl}, {2'b0, CTL_RAW});

    // Forwarding selects, MEM beats WB for the same register
    step(); idle();
    EX_Rs = 9; EX_Rt = 9; MEM_Rd = 9; MEM_RegWrite = 1;
    #1 check("fwd_mem_a", {6'b0, FwdA}, {6'b0, (FWD ? 2'b10 : 2'b00)});
    WB_Rd = 9; WB_RegWrite = 1;
    #1 check("fwd_mem_over_wb_a", {6'b0, FwdA}, {6'b0, (FWD ? 2'b10 : 2'b00)});
    check("fwd_mem_over_wb_b", {6'b0, FwdB}, {6'b0, (FWD ? 2'b10 : 2'b00)});
    EX_Rt = 5; WB_Rd = 5;
    #1 check("fwd_wb_b", {6'b0, FwdB}, {6'b0, (FWD ? 2'b01 : 2'b00)});
    EX_Rs = 0; MEM_Rd = 0;
    #1 check("fwd_zero_a", {6'b0, FwdA}, 8'h00);
    check("fwd_ctl", {2'b0, ctl}, {2'b0, CTL_RUN});

    // Non-load RAW: two stall cycles without forwarding, none with it
    step(); idle();
    ID_Rs = 9; ID_UsesRs = 1; EX_Rd = 9; EX_RegWrite = 1;
    #1 check("raw_ex", {2'b0, ctl}, {2'b0, (FWD ? CTL_RUN : CTL_RAW)});
    step(); idle();
    ID_Rs = 9; ID_UsesRs = 1; MEM_Rd = 9; MEM_RegWrite = 1;
    #1 check("raw_mem", {2'b0, ctl}, {2'b0, (FWD ? CTL_RUN : CTL_RAW)});
    step(); idle();
    ID_Rs = 9; ID_UsesRs = 1; WB_Rd = 9; WB_RegWrite = 1;
    #1 check("raw_wb_free", {2'b0, ctl}, {2'b0, CTL_RUN});

    // Redirect overrides a concurrent RAW stall
    step(); idle();
    ID_Rs = 8; ID_UsesRs = 1; EX_Rd = 8; EX_RegWrite = 1; EX_MemRead = 1; EX_Redirect = 1;
    #1 check("redirect_raw", {2'b0, ctl}, {2'b0, CTL_REDIR});

    // mul occupies EX for three cycles, then back-to-back mul restarts
    step(); idle();
    EX_IsMul = 1;
    #1 check("mul_c0_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    check("mul_c0_busy", {7'b0, MulBusy}, 8'h00);
    step();
    check("mul_c1_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    check("mul_c1_busy", {7'b0, MulBusy}, 8'h01);
    step();
    check("mul_release", {2'b0, ctl}, {2'b0, CTL_RUN});
    step();
    EX_Redirect = 1;
    #1 check("mul2_c0_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    check("mul2_c0_busy", {7'b0, MulBusy}, 8'h00);
    step();
    check("mul2_c1_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    step();
    EX_Redirect = 0;
    #1 check("mul2_release", {2'b0, ctl}, {2'b0, CTL_RUN});
    step(); idle();
    #1 check("mul_done_busy", {7'b0, MulBusy}, 8'h00);

    // Reset in the middle of MUL_WAIT
    EX_IsMul = 1;
    step();
    check("mulrst_busy", {7'b0, MulBusy}, 8'h01);
    Reset = 1;
    #1 check("mulrst_ctl", {2'b0, ctl}, {2'b0, CTL_RST});
    check("mulrst_busy0", {7'b0, MulBusy}, 8'h00);
    step();
    Reset = 0;
    #1 check("mulrst_restart_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    check("mulrst_restart_busy", {7'b0, MulBusy}, 8'h00);
    step();
    check("mulrst_c1_ctl", {2'b0, ctl}, {2'b0, CTL_MUL});
    step();
    check("mulrst_release", {2'b0, ctl}, {2'b0, CTL_RUN});
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
